led_rgb_driver: RTL and testbench
=================================

# led_rgb_driver

Output stage of the LED datapath. Consumes the rotating pattern from the shift register and the enable tick from the speed counter, and drives the three LED banks (red/main, green, blue). Adds a colour state machine that advances one colour per full pattern rotation, plus a PWM brightness gate. Sits between the shift register and the board LED pins.

## Interface

**Parameters**
- `NB_LEDS`, default 4: LED count per bank; width of the pattern.
- `NB_PWM`, default 8: width of the PWM counter and of the duty input.
- `TICKS_PER_COLOR`, default 4: number of enable ticks per colour step in auto mode. Minimum 1.

**Ports** (clock and reset first)
- `clock` input, 1: single system clock; all logic on the rising edge.
- `i_reset` input, 1: asynchronous, active-low reset.
- `i_enable` input, 1: one-cycle tick from the speed counter.
- `i_shift` input, `NB_LEDS`: current pattern from the shift register.
- `i_mode` input, 1: 0 = fixed colour, 1 = auto cycle.
- `i_color` input, 2: colour in fixed mode. 00 red, 01 green, 10 blue, 11 white.
- `i_duty` input, `NB_PWM`: brightness.
- `o_led` output, `NB_LEDS`: red/main bank.
- `o_led_g` output, `NB_LEDS`: green bank.
- `o_led_b` output, `NB_LEDS`: blue bank.
- `o_color` output, 2: current colour state (same encoding as `i_color`).

## Operation

**Reset**
- Reset asserted (`i_reset`=0) clears everything immediately, regardless of the clock:
  - colour state = RED
  - tick counter = 0
  - PWM counter = 0
  - `o_led` = `o_led_g` = `o_led_b` = 0
  - `o_color` = 00
- Reset applied mid-operation aborts the current step. There is no resume.

**Colour FSM**
- States: RED, GREEN, BLUE, WHITE.
- Fixed mode (`i_mode`=0):
  - State loads `i_color` every cycle.
  - Tick counter is held at 0.
  - `i_enable` is ignored.
- Auto mode (`i_mode`=1):
  - Each `i_enable` increments the tick counter.
  - On an `i_enable` while the counter equals `TICKS_PER_COLOR`-1, the counter wraps to 0 and the state advances RED→GREEN→BLUE→RED.
  - WHITE advances to RED on its first step.
  - Entering auto mode keeps the current state and a zeroed counter.

**PWM**
- Free-running `NB_PWM`-bit counter; wraps from all-ones to 0.
- The gate `pwm_on` is:
  - 1 when `i_duty` is all-ones (always on);
  - otherwise `pwm_cnt < i_duty`.
- So `i_duty`=0 gives fully dark, and duty d (below max) gives on for d of every 2^`NB_PWM` cycles.

**Bank mapping** (each bank is `i_shift` AND `pwm_on` when its colour is active, else 0)
- RED → `o_led` only.
- GREEN → `o_led_g` only.
- BLUE → `o_led_b` only.
- WHITE → all three banks.

## Timing
- All outputs are registered.
- A change on `i_shift`, `i_duty` or the PWM compare reaches the banks 1 cycle later.
- `o_color` reflects the state register with no added latency.
- The banks use the colour state value from before the edge, so a colour change is visible on the banks 1 cycle after it appears on `o_color`.
- Auto-mode step: the `i_enable` sampled at edge N updates the state at edge N. The banks switch colour at edge N+1.
- `i_mode` falling on the same edge as a wrapping `i_enable`: fixed mode wins; the state loads `i_color`.
- `i_enable` held high for multiple cycles counts once per cycle. No edge detection.
- No handshake and no backpressure: upstream ticks are never dropped in auto mode.

## Structure
- Shared package `led_pkg` holds:
  - the 2-bit colour encoding constants `COLOR_RED`, `COLOR_GREEN`, `COLOR_BLUE`, `COLOR_WHITE`;
  - the FSM state type using that encoding.
- `i_color`, `o_color` and the FSM share the package encoding.
- One sub-module, `pwm_gen`:
  - parameter `NB_PWM`;
  - inputs `clock`, `i_reset`, `i_duty`;
  - output `o_pwm`, combinational from the counter register.
- The FSM, tick counter and output registers live in `led_rgb_driver`.

## Test plan
- **Reset:** hold `i_reset`=0 with `i_shift`=4'b1010, `i_duty`=8'hFF → all banks 0 and `o_color`=00. Release → `o_led`=4'b1010 one cycle later, green and blue banks 0.
- **Fixed green, full brightness:** `i_mode`=0, `i_color`=01, `i_duty`=8'hFF, `i_shift`=4'b0001 → `o_led_g`=4'b0001 every cycle; `o_led`=`o_led_b`=0; eight `i_enable` pulses leave `o_color`=01.
- **Auto cycle:** `i_mode`=1, `TICKS_PER_COLOR`=4, `i_duty`=8'hFF → `o_color` goes 00→01 on the 4th `i_enable`, 01→10 on the 8th, 10→00 on the 12th; the active bank follows one cycle later.
- **PWM duty:** `i_duty`=8'd64, fixed red, `i_shift`=4'b1111 → `o_led`=4'b1111 for exactly 64 of every 256 cycles. `i_duty`=0 → `o_led` is 0 for 512 cycles.
- **White and mode switch:** `i_color`=11 → all banks equal `i_shift`. Switch `i_mode` to 1 → first wrap gives `o_color`=00. `i_mode` 1→0 coincident with a wrapping tick → `o_color`=`i_color`.
- **Async reset mid-operation:** assert `i_reset`=0 between clock edges during auto GREEN with the tick counter at 2 → outputs clear before the next edge. After release, 4 ticks are needed to reach GREEN.

Source files
------------

// File: rtl/led_pkg.sv
// Shared colour encoding and FSM state type for the RGB LED output stage.
package led_pkg;

   // Colour state; the member values double as the i_color/o_color encoding.
   typedef enum logic [1:0] {
      COLOR_RED   = 2'b00,
      COLOR_GREEN = 2'b01,
      COLOR_BLUE  = 2'b10,
      COLOR_WHITE = 2'b11
   } color_e;

   // Auto-cycle successor: RED->GREEN->BLUE->RED, WHITE falls back to RED.
   function automatic color_e next_color(input color_e c);
      case (c)
         COLOR_RED:   next_color = COLOR_GREEN;
         COLOR_GREEN: next_color = COLOR_BLUE;
         default:     next_color = COLOR_RED;
      endcase
   endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with a duty compare; all-ones duty means always on.
module pwm_gen
   import led_pkg::*;
#(
   parameter int unsigned NB_PWM = 8
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic [NB_PWM-1:0] i_duty,
   output logic              o_pwm
);

   logic [NB_PWM-1:0] r_cnt;

   // Counter wraps naturally from all-ones to zero.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) r_cnt <= '0;
      else          r_cnt <= r_cnt + NB_PWM'(1);
   end

   // Gate is combinational from the counter register.
   assign o_pwm = (&i_duty) | (r_cnt < i_duty);

endmodule

// File: rtl/led_rgb_driver.sv
// LED output stage: colour FSM, tick counter and registered RGB bank drivers.
module led_rgb_driver
   import led_pkg::*;
#(
   parameter int unsigned NB_LEDS         = 4,
   parameter int unsigned NB_PWM          = 8,
   parameter int unsigned TICKS_PER_COLOR = 4
) (
   input  logic               clock,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic [NB_LEDS-1:0] i_shift,
   input  logic               i_mode,
   input  logic [1:0]         i_color,
   input  logic [NB_PWM-1:0]  i_duty,
   output logic [NB_LEDS-1:0] o_led,
   output logic [NB_LEDS-1:0] o_led_g,
   output logic [NB_LEDS-1:0] o_led_b,
   output logic [1:0]         o_color
);

   localparam int unsigned NB_TICK = (TICKS_PER_COLOR > 1) ? $clog2(TICKS_PER_COLOR) : 1;
   localparam logic [NB_TICK-1:0] TICK_LAST = NB_TICK'(TICKS_PER_COLOR - 1);

   color_e               r_state;
   logic [NB_TICK-1:0]   r_tick;
   logic [NB_LEDS-1:0]   r_led_r;
   logic [NB_LEDS-1:0]   r_led_g;
   logic [NB_LEDS-1:0]   r_led_b;
   logic                 w_pwm;
   logic [NB_LEDS-1:0]   w_gated;
   logic                 w_r_on;
   logic                 w_g_on;
   logic                 w_b_on;

   pwm_gen #(
      .NB_PWM (NB_PWM)
   ) u_pwm (
      .clock   (clock),
      .i_reset (i_reset),
      .i_duty  (i_duty),
      .o_pwm   (w_pwm)
   );

   assign w_gated = i_shift & {NB_LEDS{w_pwm}};
   assign w_r_on  = (r_state == COLOR_RED)   || (r_state == COLOR_WHITE);
   assign w_g_on  = (r_state == COLOR_GREEN) || (r_state == COLOR_WHITE);
   assign w_b_on  = (r_state == COLOR_BLUE)  || (r_state == COLOR_WHITE);

   // Colour FSM and tick counter; fixed mode overrides any tick on the same edge.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= COLOR_RED;
         r_tick  <= '0;
      end else if (!i_mode) begin
         r_state <= color_e'(i_color);
         r_tick  <= '0;
      end else if (i_enable) begin
         if (r_tick == TICK_LAST) begin
            r_tick  <= '0;
            r_state <= next_color(r_state);
         end else begin
            r_tick  <= r_tick + NB_TICK'(1);
         end
      end
   end

   // Bank registers use the pre-edge colour, so banks trail o_color by one cycle.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         r_led_r <= '0;
         r_led_g <= '0;
         r_led_b <= '0;
      end else begin
         r_led_r <= w_r_on ? w_gated : '0;
         r_led_g <= w_g_on ? w_gated : '0;
         r_led_b <= w_b_on ? w_gated : '0;
      end
   end

   assign o_led   = r_led_r;
   assign o_led_g = r_led_g;
   assign o_led_b = r_led_b;
   assign o_color = r_state;

endmodule

// File: tb/tb_led_rgb_driver.sv
// Directed self-checking bench for led_rgb_driver (default parameters).
module tb_led_rgb_driver;

   logic       clock;
   logic       i_reset;
   logic       i_enable;
   logic [3:0] i_shift;
   logic       i_mode;
   logic [1:0] i_color;
   logic [7:0] i_duty;
   logic [3:0] o_led;
   logic [3:0] o_led_g;
   logic [3:0] o_led_b;
   logic [1:0] o_color;

   int n_tests = 0;
   int n_fail  = 0;

   led_rgb_driver #(
      .NB_LEDS         (4),
      .NB_PWM          (8),
      .TICKS_PER_COLOR (4)
   ) dut (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_enable (i_enable),
      .i_shift  (i_shift),
      .i_mode   (i_mode),
      .i_color  (i_color),
      .i_duty   (i_duty),
      .o_led    (o_led),
      .o_led_g  (o_led_g),
      .o_led_b  (o_led_b),
      .o_color  (o_color)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected banks for a colour that was active before the last edge.
   task automatic chk_banks(input string tag, input logic [1:0] c, input logic [3:0] s);
      chk({tag, "_r"}, {28'd0, o_led},   {28'd0, ((c == 2'b00) || (c == 2'b11)) ? s : 4'b0000});
      chk({tag, "_g"}, {28'd0, o_led_g}, {28'd0, ((c == 2'b01) || (c == 2'b11)) ? s : 4'b0000});
      chk({tag, "_b"}, {28'd0, o_led_b}, {28'd0, ((c == 2'b10) || (c == 2'b11)) ? s : 4'b0000});
   endtask

   initial begin
      logic [1:0] exp_c;
      logic [1:0] prev_c;
      int         on_cnt;
      int         bad_cnt;

      // Reset held low
      i_reset  = 1'b0;
      i_enable = 1'b0;
      i_shift  = 4'b1010;
      i_mode   = 1'b0;
      i_color  = 2'b00;
      i_duty   = 8'hFF;
      step();
      step();
      chk_banks("rst", 2'b00, 4'b0000);
      chk("rst_color", {30'd0, o_color}, 32'd0);

      // Release: red bank shows pattern one edge later
      i_reset = 1'b1;
      step();
      chk_banks("rel", 2'b00, 4'b1010);

      // Fixed green, full brightness, enables ignored
      i_color = 2'b01;
      i_shift = 4'b0001;
      step();
      step();
      for (int i = 0; i < 8; i++) begin
         i_enable = 1'b1;
         step();
         i_enable = 1'b0;
         chk_banks("fixg", 2'b01, 4'b0001);
         step();
      end
      chk("fixg_color", {30'd0, o_color}, 32'd1);

      // Auto cycle from red: colour steps every 4th enable
      i_color = 2'b00;
      step();
      step();
      i_mode = 1'b1;
      prev_c = 2'b00;
      for (int k = 1; k <= 12; k++) begin
         exp_c = ((k / 4) % 3 == 0) ? 2'b00 : (((k / 4) % 3 == 1) ? 2'b01 : 2'b10);
         i_enable = 1'b1;
         step();
         i_enable = 1'b0;
         chk($sformatf("auto_c%0d", k), {30'd0, o_color}, {30'd0, exp_c});
         chk_banks($sformatf("auto_old%0d", k), prev_c, 4'b0001);
         step();
         chk_banks($sformatf("auto_new%0d", k), exp_c, 4'b0001);
         prev_c = exp_c;
      end

      // PWM duty 64, fixed red: exactly 64 of 256 cycles on
      i_mode  = 1'b0;
      i_color = 2'b00;
      i_shift = 4'b1111;
      i_duty  = 8'd64;
      step();
      step();
      on_cnt  = 0;
      bad_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         if (o_led == 4'b1111) on_cnt++;
         else if (o_led != 4'b0000) bad_cnt++;
         step();
      end
      chk("pwm64_on", on_cnt, 32'd64);
      chk("pwm64_bad", bad_cnt, 32'd0);

      // Duty 0: fully dark
      i_duty = 8'd0;
      step();
      on_cnt = 0;
      for (int i = 0; i < 512; i++) begin
         if (o_led != 4'b0000) on_cnt++;
         step();
      end
      chk("pwm0_dark", on_cnt, 32'd0);

      // White: all banks follow the pattern
      i_duty  = 8'hFF;
      i_color = 2'b11;
      i_shift = 4'b0110;
      step();
      step();
      chk_banks("white", 2'b11, 4'b0110);
      chk("white_color", {30'd0, o_color}, 32'd3);

      // Enter auto from white; enable held high counts once per cycle
      i_mode   = 1'b1;
      i_enable = 1'b1;
      step();
      step();
      step();
      chk("w2a_pre", {30'd0, o_color}, 32'd3);
      step();
      chk("w2a_wrap", {30'd0, o_color}, 32'd0);

      // Mode drop coincident with a wrapping tick: fixed colour wins
      step();
      step();
      step();
      chk("tie_pre", {30'd0, o_color}, 32'd0);
      i_color = 2'b10;
      i_mode  = 1'b0;
      step();
      i_enable = 1'b0;
      chk("tie_fixed", {30'd0, o_color}, 32'd2);

      // Auto green with tick counter at 2, then async reset between edges
      i_color = 2'b00;
      step();
      i_mode   = 1'b1;
      i_shift  = 4'b1111;
      i_enable = 1'b1;
      for (int i = 0; i < 6; i++) step();
      i_enable = 1'b0;
      chk("pre_rst_color", {30'd0, o_color}, 32'd1);
      step();
      chk_banks("pre_rst", 2'b01, 4'b1111);
      #2;
      i_reset = 1'b0;
      #1;
      chk_banks("async_rst", 2'b00, 4'b0000);
      chk("async_rst_color", {30'd0, o_color}, 32'd0);
      step();
      i_reset = 1'b1;

      // After release the counter restarts: 4 ticks to reach green
      i_enable = 1'b1;
      step();
      step();
      step();
      chk("post_rst_3", {30'd0, o_color}, 32'd0);
      step();
      i_enable = 1'b0;
      chk("post_rst_4", {30'd0, o_color}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
